// File: rtl/frame_buffer_arbiter_if.sv
// Bus between the frame-buffer arbiter, its clients and the pixel RAM.
// slave is the arbiter's view; master is the clients/RAM view.
interface frame_buffer_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int NUM_WR = 4
);
  logic                   vid_req;
  logic [9:0]             vid_x;
  logic [8:0]             vid_y;
  logic [DATA_W-1:0]      vid_rgb;
  logic                   vid_valid;
  logic [NUM_WR-1:0]      wr_req;
  logic [NUM_WR*10-1:0]   wr_x;
  logic [NUM_WR*9-1:0]    wr_y;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]      wr_grant;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   clear_done;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_we;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport slave (
    input  vid_req, vid_x, vid_y,
    output vid_rgb, vid_valid,
    input  wr_req, wr_x, wr_y, wr_data,
    output wr_grant,
    input  clear_start,
    output clear_busy, clear_done,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output vid_req, vid_x, vid_y,
    input  vid_rgb, vid_valid,
    output wr_req, wr_x, wr_y, wr_data,
    input  wr_grant,
    output clear_start,
    input  clear_busy, clear_done,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/frame_buffer_arbiter.sv
// Single-port frame-buffer owner: video reads first, then the
// clear sequencer, then round-robin game writers.
module frame_buffer_arbiter #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int NUM_WR = 4,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input logic CLOCK_50,
  input logic reset,
  frame_buffer_arbiter_if.slave bus
);

  localparam int LG_W = $clog2(NUM_WR);
  localparam logic [ADDR_W-1:0] LAST_A =
    ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [LG_W-1:0]   last_q, last_d;
  logic              done_pend_q, done_pend_d;
  logic              done_q;
  logic              vp1_q, vh1_q;
  logic              vp2_q, vh2_q;
  logic              vld_q;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic              mwe_q, mwe_d;
  logic [DATA_W-1:0] mwd_q, mwd_d;

  function automatic logic in_rng(
    input logic [9:0] x,
    input logic [8:0] y
  );
    return (32'(x) < WIDTH) && (32'(y) < HEIGHT);
  endfunction

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [9:0] x,
    input logic [8:0] y
  );
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  logic              vid_hit;
  logic [ADDR_W-1:0] vid_addr;

  assign vid_hit  = bus.vid_req &
                    in_rng(bus.vid_x, bus.vid_y);
  assign vid_addr = pix_addr(bus.vid_x, bus.vid_y);

  // Round-robin search starting after the last winner
  logic              wr_found;
  logic [LG_W-1:0]   wr_sel;
  logic [LG_W-1:0]   cand;
  logic              wr_ok;
  logic [9:0]        sx;
  logic [8:0]        sy;
  logic [DATA_W-1:0] sd;
  logic [NUM_WR-1:0] grant;

  always_comb begin
    wr_found = 1'b0;
    wr_sel   = last_q;
    cand     = last_q;
    for (int k = 1; k <= NUM_WR; k++) begin
      cand = LG_W'((int'(last_q) + k) % NUM_WR);
      if (!wr_found && bus.wr_req[cand]) begin
        wr_found = 1'b1;
        wr_sel   = cand;
      end
    end
  end

  always_comb begin
    sx    = bus.wr_x[wr_sel * 10 +: 10];
    sy    = bus.wr_y[wr_sel * 9 +: 9];
    sd    = bus.wr_data[wr_sel * DATA_W +: DATA_W];
    wr_ok = wr_found && (state_q == IDLE) &&
            !vid_hit && reset;
    grant = '0;
    if (wr_ok) grant[wr_sel] = 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      clr_addr_q  <= '0;
      last_q      <= LG_W'(NUM_WR - 1);
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      vp1_q       <= 1'b0;
      vh1_q       <= 1'b0;
      vp2_q       <= 1'b0;
      vh2_q       <= 1'b0;
      vld_q       <= 1'b0;
      rgb_q       <= '0;
      maddr_q     <= '0;
      mwe_q       <= 1'b0;
      mwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      last_q      <= last_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_pend_q;
      vp1_q       <= bus.vid_req;
      vh1_q       <= vid_hit;
      vp2_q       <= vp1_q;
      vh2_q       <= vh1_q;
      vld_q       <= vp2_q;
      rgb_q       <= rgb_d;
      maddr_q     <= maddr_d;
      mwe_q       <= mwe_d;
      mwd_q       <= mwd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    done_pend_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.clear_start) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (!vid_hit) begin
          clr_addr_d = clr_addr_q + 1'b1;
          if (clr_addr_q == LAST_A) begin
            state_d     = IDLE;
            clr_addr_d  = '0;
            done_pend_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Port action for this cycle; idle cycles keep addr/data stable
  always_comb begin
    maddr_d = maddr_q;
    mwd_d   = mwd_q;
    mwe_d   = 1'b0;
    last_d  = last_q;
    rgb_d   = vh2_q ? bus.mem_rdata : '0;
    if (vid_hit) begin
      maddr_d = vid_addr;
    end else if (state_q == CLEAR) begin
      maddr_d = clr_addr_q;
      mwd_d   = CLEAR_COLOR;
      mwe_d   = 1'b1;
    end else if (wr_ok) begin
      last_d = wr_sel;
      if (in_rng(sx, sy)) begin
        maddr_d = pix_addr(sx, sy);
        mwd_d   = sd;
        mwe_d   = 1'b1;
      end
    end
  end

  assign bus.vid_rgb    = rgb_q;
  assign bus.vid_valid  = vld_q;
  assign bus.wr_grant   = grant;
  assign bus.clear_busy = (state_q == CLEAR);
  assign bus.clear_done = done_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_we     = mwe_q;
  assign bus.mem_wdata  = mwd_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: RAM model, vector table and
// video/write scoreboards.
module tb_frame_buffer_arbiter;
  localparam int W  = 160;
  localparam int H  = 120;
  localparam int DW = 8;
  localparam int AW = 15;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_arbiter_if #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW)
  ) bus ();

  frame_buffer_arbiter #(
    .WIDTH(W), .HEIGHT(H), .DATA_W(DW),
    .ADDR_W(AW), .NUM_WR(NW), .CLEAR_COLOR(8'h00)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // RAM model with one cycle of read latency
  logic [7:0] ram [0:(1<<AW)-1];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!ram_ready) begin
      for (int a = 0; a < (1<<AW); a++)
        ram[a] <= 8'(a) ^ 8'h5A;
      ram[485] <= 8'hA5;
      ram_ready <= 1'b1;
    end else begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  function automatic logic [14:0] paddr(int x, int y);
    return 15'(y * W + x);
  endfunction
  function automatic bit inr(int x, int y);
    return (x < W) && (y < H);
  endfunction
  function automatic logic [7:0] rdexp(logic [14:0] a);
    return (a == 15'd485) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    int          due;
  } exp_t;
  exp_t vq[$];
  exp_t wq[$];
  bit wmon_en = 1'b1;

  exp_t ve, we;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.vid_valid) begin
        if (vq.size() == 0) begin
          chk("vid_valid_unexp", bus.vid_valid, 0);
        end else begin
          ve = vq.pop_front();
          chk("vid_rgb", bus.vid_rgb, ve.data);
          chk("vid_latency", cyc, ve.due);
        end
      end else if (vq.size() > 0 && vq[0].due <= cyc) begin
        ve = vq.pop_front();
        chk("vid_valid_missing", bus.vid_valid, 1);
      end
      if (wmon_en) begin
        if (bus.mem_we) begin
          if (wq.size() == 0) begin
            chk("mem_we_unexp", bus.mem_we, 0);
          end else begin
            we = wq.pop_front();
            chk("wr_addr", bus.mem_addr, we.addr);
            chk("wr_data", bus.mem_wdata, we.data);
            chk("wr_latency", cyc, we.due);
          end
        end else if (wq.size() > 0 && wq[0].due <= cyc) begin
          we = wq.pop_front();
          chk("mem_we_missing", bus.mem_we, 1);
        end
      end
    end
  end

  int wx [NW];
  int wy [NW];
  logic [7:0] wd [NW];

  task automatic pack_writers();
    for (int i = 0; i < NW; i++) begin
      bus.wr_x[i*10 +: 10]  = 10'(wx[i]);
      bus.wr_y[i*9 +: 9]    = 9'(wy[i]);
      bus.wr_data[i*8 +: 8] = wd[i];
    end
  endtask

  typedef struct {
    bit         vr;
    int         vx;
    int         vy;
    logic [3:0] wr;
    logic [3:0] eg;
  } vec_t;
  vec_t tbl [18];

  int cnt, bad, gaps, gerr, early, blow, it, dn;
  bit pend_rd;
  logic [14:0] pend_a;
  int gi;

  initial begin
    tbl[0]  = '{0, 0, 0, 4'b1111, 4'b0001};
    tbl[1]  = '{0, 0, 0, 4'b1111, 4'b0010};
    tbl[2]  = '{0, 0, 0, 4'b1111, 4'b0100};
    tbl[3]  = '{0, 0, 0, 4'b1111, 4'b1000};
    tbl[4]  = '{0, 0, 0, 4'b1111, 4'b0001};
    tbl[5]  = '{1, 5, 3, 4'b1111, 4'b0000};
    tbl[6]  = '{1, 160, 0, 4'b0010, 4'b0010};
    tbl[7]  = '{1, 0, 120, 4'b0000, 4'b0000};
    tbl[8]  = '{0, 0, 0, 4'b1001, 4'b1000};
    tbl[9]  = '{0, 0, 0, 4'b1001, 4'b0001};
    tbl[10] = '{1, 1, 1, 4'b0101, 4'b0000};
    tbl[11] = '{0, 0, 0, 4'b0101, 4'b0100};
    tbl[12] = '{1, 159, 119, 4'b0101, 4'b0000};
    tbl[13] = '{0, 0, 0, 4'b0101, 4'b0001};
    tbl[14] = '{1, 0, 0, 4'b0101, 4'b0000};
    tbl[15] = '{0, 0, 0, 4'b0101, 4'b0100};
    tbl[16] = '{1, 5, 3, 4'b0101, 4'b0000};
    tbl[17] = '{0, 0, 0, 4'b0101, 4'b0001};
    for (int i = 0; i < NW; i++) begin
      wx[i] = 10 + i;
      wy[i] = 20 + i;
      wd[i] = 8'h30 + 8'(i);
    end

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      bus.vid_req     = 1'($urandom);
      bus.vid_x       = 10'($urandom);
      bus.vid_y       = 9'($urandom);
      bus.wr_req      = 4'($urandom);
      bus.wr_x        = 40'({$urandom, $urandom});
      bus.wr_y        = 36'({$urandom, $urandom});
      bus.wr_data     = 32'($urandom);
      bus.clear_start = 1'($urandom);
      #1;
      chk("rst_mem", {bus.mem_addr, bus.mem_we,
                      bus.mem_wdata}, 0);
      chk("rst_out", {bus.vid_rgb, bus.vid_valid,
                      bus.wr_grant, bus.clear_busy,
                      bus.clear_done}, 0);
    end
    @(negedge clk);
    bus.vid_req = 1'b0;
    bus.vid_x = '0;
    bus.vid_y = '0;
    bus.wr_req = '0;
    bus.clear_start = 1'b0;
    pack_writers();
    rst_n = 1'b1;

    // Table: grant order, video reads, contention
    pend_rd = 1'b0;
    pend_a = '0;
    for (int v = 0; v < 18; v++) begin
      @(negedge clk);
      if (pend_rd) begin
        chk("rd_mem_addr", bus.mem_addr, pend_a);
        chk("rd_mem_we", bus.mem_we, 0);
      end
      if (v == 0) chk("idle_busy", bus.clear_busy, 0);
      bus.vid_req = tbl[v].vr;
      bus.vid_x   = 10'(tbl[v].vx);
      bus.vid_y   = 9'(tbl[v].vy);
      bus.wr_req  = tbl[v].wr;
      #1;
      chk($sformatf("grant_v%0d", v), bus.wr_grant, tbl[v].eg);
      pend_rd = tbl[v].vr && inr(tbl[v].vx, tbl[v].vy);
      pend_a  = paddr(tbl[v].vx, tbl[v].vy);
      if (tbl[v].vr)
        vq.push_back('{pend_a,
          pend_rd ? rdexp(pend_a) : 8'h00, cyc + 3});
      gi = -1;
      for (int i = 0; i < NW; i++)
        if (tbl[v].eg[i]) gi = i;
      if (gi >= 0)
        wq.push_back('{paddr(wx[gi], wy[gi]), wd[gi], cyc + 1});
    end
    @(negedge clk);
    if (pend_rd) begin
      chk("rd_mem_addr", bus.mem_addr, pend_a);
      chk("rd_mem_we", bus.mem_we, 0);
    end
    bus.vid_req = 1'b0;
    bus.wr_req  = '0;

    // Granted writer with out-of-range coordinates
    wx[3] = 200;
    pack_writers();
    bus.wr_req = 4'b1000;
    #1;
    chk("oor_grant", bus.wr_grant, 4'b1000);
    @(negedge clk);
    chk("oor_no_we", bus.mem_we, 0);
    bus.wr_req = '0;
    wx[3] = 13;
    pack_writers();
    repeat (5) @(negedge clk);

    // Full clear with a writer waiting and a stray restart pulse
    wmon_en = 1'b0;
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    bus.wr_req = 4'b0001;
    cnt = 0; bad = 0; gaps = 0; gerr = 0;
    early = 0; blow = 0;
    for (it = 0; it < 20000; it++) begin
      #1;
      if (bus.mem_we) begin
        if (bus.mem_addr != 15'(cnt) ||
            bus.mem_wdata != 8'h00) bad++;
        cnt++;
      end else if (cnt > 0) begin
        gaps++;
      end
      if (bus.clear_busy && bus.wr_grant != 0) gerr++;
      if (bus.clear_done) early++;
      if (cnt < 19200 && !bus.clear_busy) blow++;
      if (cnt == 19200) break;
      @(negedge clk);
      bus.clear_start = (cnt == 50);
    end
    bus.clear_start = 1'b0;
    chk("clr_count", cnt, 19200);
    chk("clr_bad_wr", bad, 0);
    chk("clr_gaps", gaps, 0);
    chk("clr_grant", gerr, 0);
    chk("clr_done_early", early, 0);
    chk("clr_busy_low", blow, 0);
    chk("post_clr_grant", bus.wr_grant, 4'b0001);
    @(negedge clk);
    chk("clr_done", bus.clear_done, 1);
    chk("clr_busy_end", bus.clear_busy, 0);
    chk("post_clr_we", bus.mem_we, 1);
    chk("post_clr_addr", bus.mem_addr, paddr(wx[0], wy[0]));
    chk("post_clr_data", bus.mem_wdata, wd[0]);
    bus.wr_req = '0;
    @(negedge clk);
    chk("clr_done_pulse", bus.clear_done, 0);
    chk("post_clr_idle_we", bus.mem_we, 0);

    // Clear aborted by reset at write 100
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    cnt = 0;
    for (it = 0; it < 300 && cnt < 100; it++) begin
      @(negedge clk);
      if (bus.mem_we) cnt++;
    end
    chk("abort_count", cnt, 100);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.clear_busy, 0);
    chk("abort_we", bus.mem_we, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0; blow = 0; bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.clear_done) dn++;
      if (bus.clear_busy) blow++;
      if (bus.mem_we) bad++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle", blow, 0);
    chk("abort_no_we", bad, 0);
    wmon_en = 1'b1;
    bus.wr_req = 4'b1111;
    #1;
    chk("abort_rr_reset", bus.wr_grant, 4'b0001);
    wq.push_back('{paddr(wx[0], wy[0]), wd[0], cyc + 1});
    @(negedge clk);
    bus.wr_req = '0;
    repeat (5) @(negedge clk);
    chk("vq_drained", vq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Owns the single port of the pixel frame-buffer RAM and shares it between three users. The video scan path reads one pixel per request at a fixed latency and always has top priority. A built-in clear sequencer floods the buffer with a background colour. Game-logic writers (Pac-Man, ghosts, maze/pellet renderer) share the remaining write bandwidth round-robin. The block sits between the game sprites and the video driver's r/g/b inputs, with the RAM instance beside it.

## Interface
- WIDTH, 160: logical frame width in pixels.
- HEIGHT, 120: logical frame height in pixels.
- DATA_W, 8: pixel width (RGB332).
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- NUM_WR, 4: number of writer ports (>= 2).
- CLEAR_COLOR, 8'h00: value written by the clear sequencer.

Ports:
- CLOCK_50  in  1  sole clock; every register is on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- vid_req  in  1  pixel read request, sampled each edge.
- vid_x  in  10  read column.
- vid_y  in  9  read row.
- vid_rgb  out  DATA_W  pixel returned for a request.
- vid_valid  out  1  vid_rgb is valid this cycle.
- wr_req  in  NUM_WR  per-writer write request; held until granted.
- wr_x  in  NUM_WR*10  packed columns; writer i uses bits [i*10 +: 10].
- wr_y  in  NUM_WR*9  packed rows.
- wr_data  in  NUM_WR*DATA_W  packed pixel data.
- wr_grant  out  NUM_WR  one-hot; combinational accept.
- clear_start  in  1  pulse that starts a full-buffer clear.
- clear_busy  out  1  clear sequencer is active.
- clear_done  out  1  one-cycle pulse when the clear finishes.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data; one cycle of latency after the address edge.

## Operation
- Address rule: addr = y*WIDTH + x, computed at ADDR_W bits without truncation error. The coordinate pair is in range only when x < WIDTH and y < HEIGHT.
- Priority on each cycle: video read, then clear, then writers. Exactly one port action is issued per cycle.
- Video path:
  - An in-range vid_req issues a read with mem_we = 0.
  - An out-of-range vid_req issues no RAM access, but still returns vid_rgb = 0 with vid_valid at the normal latency.
  - A cycle freed by an out-of-range vid_req goes to clear or to the writers.
- State machine has two states, IDLE and CLEAR.
  - In IDLE, clear_start moves the block to CLEAR and sets clear_addr = 0.
  - In CLEAR, each cycle without an in-range vid_req writes CLEAR_COLOR at clear_addr, then increments clear_addr.
  - The write to address WIDTH*HEIGHT-1 returns the block to IDLE and pulses clear_done on the following cycle.
  - clear_busy = 1 exactly while in CLEAR.
  - clear_start during CLEAR is ignored; the clear does not restart.
- Writers:
  - Writers are served only in IDLE, and only on cycles with no in-range vid_req.
  - The round-robin search starts at index (last_grant+1) mod NUM_WR.
  - Grant goes to the first writer found with wr_req set. That writer's wr_grant is high during the same cycle, and the transfer completes at the next edge. last_grant is then updated.
  - A granted write with out-of-range coordinates is consumed (grant given), but mem_we stays 0.
  - wr_grant = 0 whenever a video read or a clear owns the cycle.
- Reset:
  - All outputs are 0; state = IDLE; clear_addr = 0; last_grant = NUM_WR-1, so writer 0 wins first.
  - wr_grant is forced to 0 while reset = 0.
  - Reset asserted mid-clear aborts the clear with no clear_done pulse; buffer contents are left undefined.

## Timing
- Edge E0 samples a request. mem_addr, mem_we and mem_wdata hold its action from E0 to E1, and the RAM captures it at E1.
- For a video read, mem_rdata is valid after E1. vid_rgb and vid_valid are registered at E2, so they are valid for one cycle, 2 cycles after the request is sampled.
- Back-to-back vid_req every cycle is supported at full throughput. The video driver's 25 MHz cadence (one request every 2 cycles) leaves every other cycle free for clear or writers.
- Clear duration = WIDTH*HEIGHT + (number of in-range vid_req cycles during the clear) cycles. clear_done comes 1 cycle after the final write edge.
- Writer fairness: with all NUM_WR requesting continuously and no video, each writer is granted once every NUM_WR free cycles.

## Test plan
- Reset: hold reset=0 with random inputs. Required: all outputs 0 and wr_grant=0. After release, wr_req=4'b1111 with no video gives grant order 0,1,2,3,0.
- Video read: preload RAM[3*160+5]=8'hA5, then vid_req with x=5, y=3. Required: mem_addr=485 and mem_we=0 one cycle later; vid_rgb=8'hA5 with vid_valid 2 cycles after the request.
- Out-of-range: vid_req with x=160, y=0. Required: no read, vid_rgb=0 with vid_valid at +2. A pending writer 1 is granted in that same cycle.
- Contention: vid_req on alternate cycles, with writers 0 and 2 holding requests. Required: grants occur only on non-video cycles, alternate 0,2,0,2, and each grant produces mem_we with the matching address and data.
- Clear: clear_start with no video traffic. Required: 19200 consecutive writes of 8'h00 at addresses 0 to 19199, no wr_grant during the clear, clear_done one cycle after the last write, and clear_busy low on the same cycle as clear_done.
- Abort: reset=0 at clear write 100. Required: the block returns to IDLE, and clear_done never pulses.
